// File: rtl/fetch_unit_if.sv
// ----------------------------------------------------------------------------
// fetch_unit_if
//   Bundles the fetch unit's bus-level signals: the instruction-memory
//   request/response channel, the branch redirect input, and the decode-side
//   instruction queue output.
//
//   master : fetch-unit side (drives requests and the decode output)
//   slave  : environment side (memory, branch unit, decode)
//
//   imem_req_valid/ready/addr : fetch request handshake
//   imem_rsp_valid/data       : in-order instruction response
//   redirect_valid/pc         : single-cycle flushing redirect
//   out_valid/ready/inst/pc   : queue head toward decode
// ----------------------------------------------------------------------------
interface fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;

    modport master (
        output imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//   Sequential instruction-fetch front end: PC generation, single-outstanding
//   req/rsp handshake to instruction memory, a QDEPTH-entry instruction queue
//   toward decode, and a flushing redirect for taken branches/jumps.
//
// Ports
//   clk    : clock, all state on posedge
//   rst_n  : asynchronous active-low reset
//   bus    : fetch_unit_if.master (imem req/rsp, redirect, decode output)
//   perf_fetched / perf_flushed : 32-bit event counters, present only when
//            FETCH_PERF_EN is defined
//
// Parameters
//   ADDR_W, INST_W : address / instruction widths
//   RESET_PC       : PC loaded on reset (word aligned)
//   QDEPTH         : queue entries, power of 2, >= 2
//
// Optional feature macro: FETCH_PERF_EN
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                QDEPTH   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_flushed
`endif
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    generate
        if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_qdepth
            $error("fetch_unit: QDEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,   // free to issue
        S_WAIT  = 2'd1,   // response outstanding, will be queued
        S_DROP  = 2'd2    // response outstanding, will be discarded
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_pc;

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [INST_W-1:0] q_inst [QDEPTH];
    logic [ADDR_W-1:0] q_pc   [QDEPTH];
    logic [INST_W-1:0] out_inst_q;
    logic [ADDR_W-1:0] out_pc_q;

    logic              redir;
    logic              not_full;
    logic              req_valid;
    logic              accept;
    logic              push;
    logic              pop;
    logic [PTR_W-1:0]  head_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              head_is_new;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        redir     = bus.redirect_valid;
        not_full  = (count < CNT_W'(QDEPTH));
        // rst_n gate keeps the request low while reset is held; the FSM
        // state alone would otherwise already say "FETCH".
        req_valid = rst_n && (state == S_FETCH) && not_full && !redir;
        accept    = req_valid && bus.imem_req_ready;
        push      = (state == S_WAIT) && bus.imem_rsp_valid && !redir;
        pop       = (count != '0) && bus.out_ready && !redir;
        head_nxt  = pop ? head + PTR_W'(1) : head;
        cnt_nxt   = count + CNT_W'(push) - CNT_W'(pop);
        // After this cycle the head slot is the one being written now only
        // when the queue holds just the new entry; take data straight from
        // the response in that case since storage is not yet updated.
        head_is_new = push && (head_nxt == tail);
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.out_valid      = (count != '0);
    assign bus.out_inst       = out_inst_q;
    assign bus.out_pc         = out_pc_q;

    // ------------------------------------------------------------------
    // Fetch FSM and PC generation
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (accept) begin
                        req_pc <= fetch_pc;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A response arriving with a redirect is simply not
                    // pushed; nothing is outstanding afterwards either way.
                    if (bus.imem_rsp_valid) state <= S_FETCH;
                    else if (redir)         state <= S_DROP;
                end
                S_DROP: begin
                    // The stale response retires the outstanding request
                    // even if another redirect lands in the same cycle.
                    if (bus.imem_rsp_valid) state <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase

            if (redir)
                fetch_pc <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
            else if (accept)
                fetch_pc <= fetch_pc + ADDR_W'(4);
        end
    end

    // ------------------------------------------------------------------
    // Instruction queue: pointers, count and registered head outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            out_inst_q <= '0;
            out_pc_q   <= '0;
        end else if (redir) begin
            // Flush: outputs keep their last value, out_valid drops.
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            head  <= head_nxt;
            count <= cnt_nxt;
            if (cnt_nxt != '0) begin
                out_inst_q <= head_is_new ? bus.imem_rsp_data : q_inst[head_nxt];
                out_pc_q   <= head_is_new ? req_pc            : q_pc[head_nxt];
            end
        end
    end

    // Entry storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[tail] <= bus.imem_rsp_data;
            q_pc[tail]   <= req_pc;
        end
    end

`ifdef FETCH_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters (wrap naturally at 2^32)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (push)  perf_fetched <= perf_fetched + 32'd1;
            if (redir) perf_flushed <= perf_flushed + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    localparam int          QD   = 4;
    localparam logic [31:0] RPC  = 32'h0000_0100;
    localparam logic [31:0] RPC2 = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(32), .INST_W(32)) bus ();
    fetch_unit_if #(.ADDR_W(32), .INST_W(32)) bus2 ();

`ifdef FETCH_PERF_EN
    logic [31:0] pf1, pl1, pf2, pl2;
`endif

    fetch_unit #(.ADDR_W(32), .INST_W(32), .RESET_PC(RPC), .QDEPTH(QD)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef FETCH_PERF_EN
        , .perf_fetched(pf1), .perf_flushed(pl1)
`endif
    );

    // Second instance only exercises PC wrap with a zero-wait memory.
    fetch_unit #(.ADDR_W(32), .INST_W(32), .RESET_PC(RPC2), .QDEPTH(QD)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
`ifdef FETCH_PERF_EN
        , .perf_fetched(pf2), .perf_flushed(pl2)
`endif
    );

    function automatic logic [31:0] imem(input logic [31:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    logic        rv2;
    logic [31:0] rd2;
    assign bus2.imem_req_ready = 1'b1;
    assign bus2.imem_rsp_valid = rv2;
    assign bus2.imem_rsp_data  = rd2;
    assign bus2.redirect_valid = 1'b0;
    assign bus2.redirect_pc    = 32'h0;
    assign bus2.out_ready      = 1'b1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv2 <= 1'b0;
            rd2 <= 32'h0;
        end else begin
            rv2 <= bus2.imem_req_valid;
            rd2 <= imem(bus2.imem_req_addr);
        end
    end

    // ------------------------------------------------------------------
    // Behavioural model: queue of {pc, inst}, one outstanding request
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        q[$];
    bit          pend, drop;
    logic [31:0] pend_pc, mpc;
    int          dly;

    int ready_pct = 100, oready_pct = 100, dly_fix = 0, dly_max = 4;
    bit          rd_req = 0;
    logic [31:0] rd_pc = 32'h0;
    bit          rel = 0;

    int total = 0, bad = 0, cyc = 0, first_vcyc = -1;
    logic [31:0] accs[$], pops[$], w_pc[$], w_inst[$];
    int          popc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pend = 0; drop = 0; dly = 0;
        pend_pc = 32'h0;
        mpc = RPC;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.out_ready      = 1'b0;
    endtask

    // One cycle: drive inputs at negedge, compare against the model, then
    // advance the model to the state after the coming posedge.
    task automatic step();
        bit rsp, acc, pop, exp_req;
        @(negedge clk);
        if (rel) begin
            rst_n = 1'b1;
            rel = 0;
            cyc = 0;
        end
        rsp = pend && (dly == 0);
        bus.imem_req_ready = ($urandom_range(99) < ready_pct);
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? imem(pend_pc) : $urandom;
        bus.out_ready      = ($urandom_range(99) < oready_pct);
        bus.redirect_valid = rd_req;
        bus.redirect_pc    = rd_pc;
        rd_req = 0;
        #1;

        chk("out_valid", {31'b0, bus.out_valid}, {31'b0, q.size() != 0});
        if (q.size() != 0) begin
            chk("out_pc", bus.out_pc, q[0].pc);
            chk("out_inst", bus.out_inst, q[0].inst);
        end
        exp_req = !pend && (q.size() < QD) && !bus.redirect_valid;
        chk("req_valid", {31'b0, bus.imem_req_valid}, {31'b0, exp_req});
        chk("req_addr", bus.imem_req_addr, mpc);

        if (bus.out_valid && first_vcyc < 0) first_vcyc = cyc;
        if (bus2.out_valid && w_pc.size() < 2 &&
            (w_pc.size() == 0 || w_pc[w_pc.size()-1] != bus2.out_pc)) begin
            w_pc.push_back(bus2.out_pc);
            w_inst.push_back(bus2.out_inst);
        end

        acc = exp_req && bus.imem_req_ready;
        pop = (q.size() != 0) && bus.out_ready && !bus.redirect_valid;
        if (pop) begin
            pops.push_back(q[0].pc);
            popc.push_back(cyc);
        end
        if (bus.redirect_valid) begin
            q.delete();
            mpc = {bus.redirect_pc[31:2], 2'b00};
            if (pend && rsp) pend = 0;
            else if (pend)   drop = 1;
        end else begin
            if (pop) void'(q.pop_front());
            if (rsp) begin
                if (!drop) q.push_back('{pc: pend_pc, inst: imem(pend_pc)});
                pend = 0;
            end
        end
        if (rsp) begin
            pend = 0;
            drop = 0;
        end
        if (acc) begin
            accs.push_back(mpc);
            pend = 1;
            drop = 0;
            pend_pc = mpc;
            mpc = mpc + 32'd4;
            dly = (dly_fix >= 0) ? dly_fix : int'($urandom_range(dly_max - 1, 0));
        end else if (pend) begin
            dly = dly - 1;
        end
        cyc++;
    endtask

    initial begin
        int amark, pmark, n;
        model_reset();

        // Reset held
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        chk("rst_req_addr", bus.imem_req_addr, 32'h100);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_out_inst", bus.out_inst, 32'd0);
        chk("rst_out_pc", bus.out_pc, 32'd0);
        chk("rst_req_addr2", bus2.imem_req_addr, RPC2);

        // Zero-wait streaming
        ready_pct = 100; oready_pct = 100; dly_fix = 0;
        rel = 1;
        repeat (10) step();
        chk("t2_first_valid_cyc", first_vcyc, 32'd2);
        if (pops.size() >= 3) begin
            chk("t2_pc0", pops[0], 32'h100);
            chk("t2_pc1", pops[1], 32'h104);
            chk("t2_pc2", pops[2], 32'h108);
            chk("t2_rate", popc[1] - popc[0], 32'd2);
        end else chk("t2_pop_count", pops.size(), 32'd3);

        // Fill with decode stalled, then drain
        rd_req = 1; rd_pc = 32'h100; oready_pct = 0;
        step();
        amark = accs.size();
        repeat (20) step();
        chk("t3_accepts", accs.size() - amark, 32'd4);
        oready_pct = 100;
        pmark = pops.size();
        repeat (12) step();
        if (pops.size() >= pmark + 4 && accs.size() > amark + 4) begin
            for (int i = 0; i < 4; i++) chk("t3_drain_pc", pops[pmark+i], 32'h100 + 32'(4*i));
            chk("t3_resume_addr", accs[amark+4], 32'h110);
        end else chk("t3_drain_count", pops.size() - pmark, 32'd4);

        // Redirect while a response is pending
        dly_fix = 3;
        n = 0;
        while (!pend && n < 20) begin step(); n++; end
        chk("t4_got_wait", {31'b0, pend}, 32'd1);
        amark = accs.size(); pmark = pops.size();
        rd_req = 1; rd_pc = 32'h203;
        step();
        n = 0;
        while (pops.size() == pmark && n < 30) begin step(); n++; end
        if (pops.size() > pmark && accs.size() > amark) begin
            chk("t4_next_req", accs[amark], 32'h200);
            chk("t4_first_pc", pops[pmark], 32'h200);
        end else chk("t4_timeout", 32'd1, 32'd0);

        // Redirect with a full queue and decode ready in the same cycle
        dly_fix = 0; oready_pct = 0;
        n = 0;
        while (!(q.size() == QD && !pend) && n < 40) begin step(); n++; end
        chk("t5_full", q.size(), QD);
        oready_pct = 100;
        pmark = pops.size();
        rd_req = 1; rd_pc = 32'h340;
        step();
        chk("t5_no_pop", pops.size(), pmark);
        @(posedge clk);
        #1;
        chk("t5_flush_valid", {31'b0, bus.out_valid}, 32'd0);
        n = 0;
        while (pops.size() == pmark && n < 20) begin step(); n++; end
        if (pops.size() > pmark) chk("t5_first_pc", pops[pmark], 32'h340);
        else chk("t5_timeout", 32'd1, 32'd0);

        // Randomized traffic
        dly_fix = -1; dly_max = 4; ready_pct = 70; oready_pct = 60;
        repeat (1500) begin
            if ($urandom_range(99) < 3) begin
                rd_req = 1;
                rd_pc = $urandom;
            end
            step();
        end

        // Reset in the middle of traffic
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mrst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        chk("mrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("mrst_out_pc", bus.out_pc, 32'd0);
        chk("mrst_req_addr", bus.imem_req_addr, 32'h100);
        rel = 1;
        repeat (400) begin
            if ($urandom_range(99) < 3) begin
                rd_req = 1;
                rd_pc = $urandom;
            end
            step();
        end

        // PC wrap on the second instance
        if (w_pc.size() == 2) begin
            chk("t6_pc0", w_pc[0], 32'hFFFF_FFFC);
            chk("t6_pc1", w_pc[1], 32'h0000_0000);
            chk("t6_inst0", w_inst[0], imem(32'hFFFF_FFFC));
            chk("t6_inst1", w_inst[1], imem(32'h0000_0000));
        end else chk("t6_count", w_pc.size(), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
